// File: rtl/uart_reg_block.sv
// uart_reg_block: APB register file, transmit request handshake and receive buffer for a UART core.
// Optional macro UART_IRQ_EN adds the IER register and a registered level interrupt.
module uart_reg_block #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [1:0]        data_bit_num_o,
    output logic              parity_en_o,
    output logic              parity_type_o,
    output logic              stop_bit_num_o,
    output logic [31:0]       tx_data_o,
    output logic              start_tx_o,
    input  logic              tx_start_ack_i,
    input  logic              tx_done_i,
    input  logic              rx_done_i,
    input  logic [31:0]       rx_data_i,
    input  logic              parity_error_i,
    output logic              host_read_data_o,
    output logic              irq_o,
    output logic [1:0]        tx_state_dbg
);

    localparam int WA = ADDR_W - 2;
    localparam logic [WA-1:0] A_TX     = WA'(0);
    localparam logic [WA-1:0] A_RX     = WA'(1);
    localparam logic [WA-1:0] A_CFG    = WA'(2);
    localparam logic [WA-1:0] A_CTRL   = WA'(3);
    localparam logic [WA-1:0] A_STATUS = WA'(4);
    localparam logic [WA-1:0] A_IER    = WA'(5);

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_BUSY = 2'd2
    } tx_state_t;

    tx_state_t state, state_nx;

    logic [31:0]   tx_data;
    logic [31:0]   rx_buf;
    logic [4:0]    cfg;
    logic          tx_done;
    logic          rx_valid;
    logic          parity_err;
    logic          overrun;
    logic [1:0]    ier;
    logic          irq;

    logic          access;
    logic [WA-1:0] word;
    logic          sel_tx, sel_rx, sel_cfg, sel_ctrl, sel_status, sel_ier, mapped;
    logic          tx_busy;
    logic          err;
    logic          wr_ok;
    logic          w1c;
    logic          start_req;
    logic          tx_done_set;
    logic          rx_read;
    logic          addr_lsb_unused;

    // Reset gates the access so no APB response or read pulse leaks out while reset_n is low.
    assign access          = psel & penable & reset_n;
    assign word            = paddr[ADDR_W-1:2];
    assign addr_lsb_unused = ^paddr[1:0];

    assign sel_tx     = (word == A_TX);
    assign sel_rx     = (word == A_RX);
    assign sel_cfg    = (word == A_CFG);
    assign sel_ctrl   = (word == A_CTRL);
    assign sel_status = (word == A_STATUS);
    assign sel_ier    = (word == A_IER);
    assign mapped     = sel_tx | sel_rx | sel_cfg | sel_ctrl | sel_status | sel_ier;

    assign tx_busy = (state != TX_IDLE);

    always_comb begin
        err = 1'b0;
        if (access) begin
            if (!mapped) begin
                err = 1'b1;
            end else if (pwrite) begin
                err = sel_rx
                    | ((sel_tx | sel_cfg) & tx_busy)
                    | (sel_ctrl & pwdata[0] & tx_busy);
            end
        end
    end

    assign wr_ok     = access & pwrite & ~err;
    assign w1c       = wr_ok & sel_status;
    assign start_req = wr_ok & sel_ctrl & pwdata[0];
    assign rx_read   = access & ~pwrite & sel_rx;

    always_comb begin
        prdata = 32'd0;
        if (access && !pwrite && !err) begin
            if (sel_tx)          prdata = tx_data;
            else if (sel_rx)     prdata = rx_buf;
            else if (sel_cfg)    prdata = {27'd0, cfg};
            else if (sel_status) prdata = {27'd0, overrun, parity_err, rx_valid, tx_done, tx_busy};
            else if (sel_ier)    prdata = {30'd0, ier};
        end
    end

    assign pslverr          = err;
    assign pready           = 1'b1;
    assign host_read_data_o = rx_read;

    // start_tx_o / tx_start_ack_i is a valid/ready pair: the request stays high from the
    // accepted CTRL start until a clock edge sees ack high, which is when the core takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= TX_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        start_tx_o  = 1'b0;
        tx_done_set = 1'b0;
        case (state)
            TX_IDLE: begin
                if (start_req) state_nx = TX_REQ;
            end
            TX_REQ: begin
                start_tx_o = 1'b1;
                if (tx_start_ack_i) state_nx = TX_BUSY;
            end
            TX_BUSY: begin
                if (tx_done_i) begin
                    state_nx    = TX_IDLE;
                    tx_done_set = 1'b1;
                end
            end
            default: state_nx = TX_IDLE;
        endcase
    end

    assign tx_state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_data <= 32'd0;
            cfg     <= 5'd0;
        end else if (wr_ok) begin
            if (sel_tx)  tx_data <= pwdata;
            if (sel_cfg) cfg     <= pwdata[4:0];
        end
    end

    // A set event in the same cycle as a W1C write takes priority over the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_done    <= 1'b0;
            rx_valid   <= 1'b0;
            rx_buf     <= 32'd0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            tx_done    <= tx_done_set | (tx_done & ~(w1c & pwdata[1]));
            parity_err <= (rx_done_i & parity_error_i) | (parity_err & ~(w1c & pwdata[3]));
            overrun    <= (rx_done_i & rx_valid & ~rx_read) | (overrun & ~(w1c & pwdata[4]));
            if (rx_done_i) begin
                rx_buf   <= rx_data_i;
                rx_valid <= 1'b1;
            end else if (rx_read) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ier <= 2'd0;
            irq <= 1'b0;
        end else begin
            if (wr_ok && sel_ier) ier <= pwdata[1:0];
            irq <= |(ier & {rx_valid, tx_done});
        end
    end
`else
    assign ier = 2'd0;
    assign irq = 1'b0;
`endif

    assign irq_o = irq;

    assign tx_data_o      = tx_data;
    assign data_bit_num_o = cfg[1:0];
    assign parity_en_o    = cfg[2];
    assign parity_type_o  = cfg[3];
    assign stop_bit_num_o = cfg[4];

endmodule

// File: tb/tb_uart_reg_block.sv
// tb_uart_reg_block: directed and randomized APB/core traffic against a behavioural model of the register block.
// Build with UART_IRQ_EN defined to exercise the interrupt enable register.
module tb_uart_reg_block;

`ifdef UART_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  paddr = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [1:0]  data_bit_num_o;
    logic        parity_en_o, parity_type_o, stop_bit_num_o;
    logic [31:0] tx_data_o;
    logic        start_tx_o;
    logic        tx_start_ack_i = 1'b0, tx_done_i = 1'b0, rx_done_i = 1'b0;
    logic [31:0] rx_data_i = '0;
    logic        parity_error_i = 1'b0;
    logic        host_read_data_o, irq_o;
    logic [1:0]  tx_state_unused;

    uart_reg_block #(.ADDR_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .data_bit_num_o(data_bit_num_o), .parity_en_o(parity_en_o),
        .parity_type_o(parity_type_o), .stop_bit_num_o(stop_bit_num_o),
        .tx_data_o(tx_data_o), .start_tx_o(start_tx_o),
        .tx_start_ack_i(tx_start_ack_i), .tx_done_i(tx_done_i),
        .rx_done_i(rx_done_i), .rx_data_i(rx_data_i), .parity_error_i(parity_error_i),
        .host_read_data_o(host_read_data_o), .irq_o(irq_o),
        .tx_state_dbg(tx_state_unused)
    );

    // scoreboard counters
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp_v);
    endtask

    // reference model: register contents and the transmit request/sending phases
    logic [31:0] m_tx_data, m_rx_buf;
    logic [4:0]  m_cfg;
    logic [1:0]  m_ier;
    bit          m_req, m_send, m_txd, m_rxv, m_perr, m_ovr, m_irq;

    task automatic model_reset();
        m_tx_data = '0; m_rx_buf = '0; m_cfg = '0; m_ier = '0;
        m_req = 0; m_send = 0; m_txd = 0; m_rxv = 0; m_perr = 0; m_ovr = 0; m_irq = 0;
    endtask

    function automatic bit exp_err();
        int w = int'(paddr) >> 2;
        bit busy = m_req || m_send;
        if (!(psel && penable)) return 1'b0;
        case (w)
            0, 2:    return pwrite && busy;
            1:       return pwrite;
            3:       return pwrite && pwdata[0] && busy;
            4, 5:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] exp_rdata();
        int w = int'(paddr) >> 2;
        bit busy = m_req || m_send;
        if (!(psel && penable) || pwrite || exp_err()) return 32'd0;
        case (w)
            0:       return m_tx_data;
            1:       return m_rx_buf;
            2:       return 32'(m_cfg);
            4:       return 32'({m_ovr, m_perr, m_rxv, m_txd, busy});
            5:       return IRQ_EN ? 32'(m_ier) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        int w     = int'(paddr) >> 2;
        bit acc   = psel && penable;
        bit err   = exp_err();
        bit wr_ok = acc && pwrite && !err;
        bit rd_rx = acc && !pwrite && (w == 1);
        bit clr   = wr_ok && (w == 4);
        bit txd_set = 0, perr_set = 0, ovr_set = 0;
        bit irq_n = IRQ_EN && ((m_ier[1] && m_rxv) || (m_ier[0] && m_txd));
        if (m_send && tx_done_i) begin
            m_send = 0;
            txd_set = 1;
        end else if (m_req && tx_start_ack_i) begin
            m_req = 0;
            m_send = 1;
        end
        if (wr_ok && w == 3 && pwdata[0]) m_req = 1;
        if (wr_ok && w == 0) m_tx_data = pwdata;
        if (wr_ok && w == 2) m_cfg = pwdata[4:0];
        if (wr_ok && w == 5 && IRQ_EN) m_ier = pwdata[1:0];
        if (rx_done_i) begin
            ovr_set  = m_rxv && !rd_rx;
            perr_set = parity_error_i;
            m_rxv    = 1;
            m_rx_buf = rx_data_i;
        end else if (rd_rx) begin
            m_rxv = 0;
        end
        m_txd  = txd_set  || (m_txd  && !(clr && pwdata[1]));
        m_perr = perr_set || (m_perr && !(clr && pwdata[3]));
        m_ovr  = ovr_set  || (m_ovr  && !(clr && pwdata[4]));
        m_irq  = irq_n;
    endtask

    // driver
    bit          rand_pulses = 0;
    logic [31:0] obs_prdata;
    logic        obs_err;
    int          n_start_hi = 0;
    int          n_host_pulse = 0;

    task automatic step(input string tag);
        if (rand_pulses) begin
            tx_start_ack_i = ($urandom_range(0, 2) == 0);
            tx_done_i      = ($urandom_range(0, 7) == 0);
            rx_done_i      = ($urandom_range(0, 7) == 0);
            rx_data_i      = $urandom;
            parity_error_i = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check({tag, ".prdata"}, prdata, exp_rdata());
        check({tag, ".pslverr"}, 32'(pslverr), 32'(exp_err()));
        check({tag, ".host_rd"}, 32'(host_read_data_o),
              32'(psel && penable && !pwrite && ((int'(paddr) >> 2) == 1)));
        check({tag, ".start_tx"}, 32'(start_tx_o), 32'(m_req));
        check({tag, ".irq"}, 32'(irq_o), 32'(m_irq));
        check({tag, ".tx_data"}, tx_data_o, m_tx_data);
        check({tag, ".cfg"}, 32'({stop_bit_num_o, parity_type_o, parity_en_o, data_bit_num_o}), 32'(m_cfg));
        check({tag, ".pready"}, 32'(pready), 32'd1);
        obs_prdata = prdata;
        obs_err    = pslverr;
        n_start_hi   += int'(start_tx_o);
        n_host_pulse += int'(host_read_data_o);
        model_step();
        @(posedge clk);
        #1;
        tx_start_ack_i = 1'b0;
        tx_done_i      = 1'b0;
        rx_done_i      = 1'b0;
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d, input string tag);
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        step({tag, ".setup"});
        penable = 1'b1;
        step(tag);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, input string tag, output logic [31:0] d);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        step({tag, ".setup"});
        penable = 1'b1;
        step(tag);
        psel = 1'b0; penable = 1'b0;
        d = obs_prdata;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    logic [31:0] rd;

    initial begin
        model_reset();
        psel = 1'b1; penable = 1'b1; paddr = 5'h10;
        repeat (3) @(posedge clk);
        #1;
        check("rst.prdata", prdata, 32'd0);
        check("rst.pslverr", 32'(pslverr), 32'd0);
        check("rst.start_tx", 32'(start_tx_o), 32'd0);
        check("rst.irq", 32'(irq_o), 32'd0);
        check("rst.tx_data", tx_data_o, 32'd0);
        check("rst.cfg", 32'({stop_bit_num_o, parity_type_o, parity_en_o, data_bit_num_o}), 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // frame configuration
        apb_write(5'h08, 32'h13, "cfg_wr");
        apb_read(5'h08, "cfg_rd", rd);
        check("cfg_readback", rd, 32'h13);
        check("cfg_dbits", 32'(data_bit_num_o), 32'd3);
        check("cfg_stop", 32'(stop_bit_num_o), 32'd1);

        // transmit: ack after 3 request cycles, done 20 cycles after the ack
        apb_write(5'h00, 32'hA5, "txd_wr");
        n_start_hi = 0;
        apb_write(5'h0C, 32'h1, "ctrl_start");
        idle(2, "req");
        tx_start_ack_i = 1'b1;
        step("req_ack");
        check("start_tx_cycles", 32'(n_start_hi), 32'd3);
        apb_read(5'h10, "st_busy", rd);
        check("status_busy", rd, 32'h1);
        apb_write(5'h0C, 32'h1, "ctrl_busy");
        check("ctrl_busy_err", 32'(obs_err), 32'd1);
        apb_write(5'h00, 32'h11, "txd_busy");
        check("txd_busy_err", 32'(obs_err), 32'd1);
        check("txd_kept", tx_data_o, 32'hA5);
        apb_write(5'h08, 32'h00, "cfg_busy");
        check("cfg_busy_err", 32'(obs_err), 32'd1);
        idle(12, "busy");
        tx_done_i = 1'b1;
        step("tx_done");
        apb_read(5'h10, "st_done", rd);
        check("status_done", rd, 32'h2);
        check("start_tx_total", 32'(n_start_hi), 32'd3);
        apb_write(5'h10, 32'h2, "w1c_txd");
        apb_read(5'h10, "st_clr", rd);
        check("status_clr", rd, 32'h0);

        // receive with parity error
        rx_data_i = 32'h5A; parity_error_i = 1'b1; rx_done_i = 1'b1;
        step("rx1");
        parity_error_i = 1'b0;
        n_host_pulse = 0;
        apb_read(5'h04, "rx_rd", rd);
        check("rx_data", rd, 32'h5A);
        check("host_read_pulses", 32'(n_host_pulse), 32'd1);
        apb_read(5'h10, "st_perr", rd);
        check("status_perr", rd, 32'h8);
        apb_write(5'h10, 32'h8, "w1c_perr");

        // overrun and its W1C
        rx_data_i = 32'h1; rx_done_i = 1'b1;
        step("rx_a");
        rx_data_i = 32'h2; rx_done_i = 1'b1;
        step("rx_b");
        apb_read(5'h10, "st_ovr", rd);
        check("overrun_set", 32'(rd[4]), 32'd1);
        apb_write(5'h10, 32'h10, "w1c_ovr");
        apb_read(5'h10, "st_ovr_clr", rd);
        check("overrun_clr", 32'(rd[4]), 32'd0);
        apb_read(5'h04, "rx_rd2", rd);
        check("rx_latest", rd, 32'h2);
        apb_write(5'h04, 32'h7, "rx_wr");
        check("rx_wr_err", 32'(obs_err), 32'd1);
        apb_read(5'h18, "unmapped", rd);
        check("unmapped_err", 32'(obs_err), 32'd1);

`ifdef UART_IRQ_EN
        apb_write(5'h14, 32'h2, "ier_wr");
        rx_data_i = 32'h33; rx_done_i = 1'b1;
        step("irq_rx");
        step("irq_lag");
        check("irq_high", 32'(irq_o), 32'd1);
        apb_read(5'h04, "irq_rd", rd);
        step("irq_fall");
        check("irq_low", 32'(irq_o), 32'd0);
`endif

        // randomized traffic
        rand_pulses = 1;
        for (int i = 0; i < 700; i++) begin
            logic [4:0]  a = 5'($urandom_range(0, 31));
            logic [31:0] d = $urandom;
            if ($urandom_range(0, 2) == 0) d = d & 32'h1F;
            case ($urandom_range(0, 2))
                0:       apb_write(a, d, "rnd_wr");
                1:       apb_read(a, "rnd_rd", rd);
                default: step("rnd_idle");
            endcase
        end
        rand_pulses = 0;

        // let the transmitter drain, then reset in the middle of a frame
        for (int i = 0; i < 50; i++) begin
            if (m_req)       tx_start_ack_i = 1'b1;
            else if (m_send) tx_done_i = 1'b1;
            step("drain");
        end
        apb_read(5'h10, "st_drain", rd);
        check("drained_idle", 32'(rd[0]), 32'd0);
        apb_write(5'h0C, 32'h1, "ctrl_start2");
        tx_start_ack_i = 1'b1;
        step("ack2");
        apb_read(5'h10, "st_busy2", rd);
        check("busy_before_rst", 32'(rd[0]), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid.start_tx", 32'(start_tx_o), 32'd0);
        check("rst_mid.tx_data", tx_data_o, 32'd0);
        check("rst_mid.irq", 32'(irq_o), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        apb_read(5'h10, "st_after_rst", rd);
        check("status_after_rst", rd, 32'h0);
        idle(3, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
